// File: rtl/player_pkg.sv
// Shared types and constants for the player motion block: FSM states,
// HID keycodes, screen bounds and the per-level spawn table.
package player_pkg;

  typedef enum logic [1:0] {WAIT, PLAY, DEAD} state_e;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  // Levels beyond the table fall back to the first spawn point.
  function automatic pos_t spawn_pos(input int unsigned lvl);
    pos_t p;
    case (lvl)
      1:       begin p.x = 10'd160; p.y = 10'd240; end
      2:       begin p.x = 10'd320; p.y = 10'd240; end
      default: begin p.x = 10'd170; p.y = 10'd240; end
    endcase
    return p;
  endfunction

  function automatic logic [9:0] clamp_axis(input int v, input int lo, input int hi);
    if (v < lo) return 10'(lo);
    if (v > hi) return 10'(hi);
    return 10'(v);
  endfunction

endpackage

// File: rtl/player_motion_if.sv
// Keyboard bundle: raw keycode slots in, decoded direction flags out.
interface player_motion_if #(
  parameter int KEYS = 6
);
  logic [KEYS-1:0][7:0] keycode;
  logic                 up;
  logic                 down;
  logic                 left;
  logic                 right;

  modport master (output keycode, input up, down, left, right);
  modport slave  (input keycode, output up, down, left, right);
endinterface

// File: rtl/player_motion_key_decode.sv
// Reduces all keycode slots to raw W/S/A/D presence flags; a key in any slot counts.
module key_decode
  import player_pkg::*;
#(
  parameter int KEYS = 6
) (
  player_motion_if.slave kb
);

  always_comb begin
    kb.up    = 1'b0;
    kb.down  = 1'b0;
    kb.left  = 1'b0;
    kb.right = 1'b0;
    for (int unsigned i = 0; i < KEYS; i++) begin
      if (kb.keycode[i] == KEY_W) kb.up    = 1'b1;
      if (kb.keycode[i] == KEY_S) kb.down  = 1'b1;
      if (kb.keycode[i] == KEY_A) kb.left  = 1'b1;
      if (kb.keycode[i] == KEY_D) kb.right = 1'b1;
    end
  end

endmodule

// File: rtl/player_motion.sv
// Per-frame player position, death/respawn sequencing and coin reset pulses.
// Optional macro PLAYER_CHECKPOINT_EN: respawn at the last checkpoint touched.
module player_motion
  import player_pkg::*;
#(
  parameter int NUM_LEVELS   = 3,
  parameter int KEYS         = 6,
  parameter int STEP         = 1,
  parameter int SIZE         = 6,
  parameter int DEATH_FRAMES = 30
) (
  input  logic                          frame_clk,
  input  logic                          Reset_n,
  input  logic [KEYS-1:0][7:0]          keycode,
  input  logic [$clog2(NUM_LEVELS)-1:0] level,
  input  logic                          level_wait,
  input  logic                          level_active,
  input  logic                          kill,
  input  logic                          checkpoint_hit,
  input  logic                          border_top,
  input  logic                          border_bottom,
  input  logic                          border_left,
  input  logic                          border_right,
  output logic [9:0]                    PlayerX,
  output logic [9:0]                    PlayerY,
  output logic [9:0]                    PlayerS,
  output logic [NUM_LEVELS-1:0]         coin_reset,
  output logic                          dead,
  output logic [15:0]                   death_count
);

  localparam int CNT_W = $clog2(DEATH_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(DEATH_FRAMES - 1);
  localparam pos_t SPAWN0 = spawn_pos(0);

  state_e                state_q, state_d;
  pos_t                  pos_q, pos_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [15:0]           deaths_q, deaths_d;
  logic [NUM_LEVELS-1:0] coin_q, coin_d;
  pos_t                  spawn, respawn, moved;
  int unsigned           lvl_idx;
  int                    dx, dy;

  player_motion_if #(.KEYS(KEYS)) keys_if ();
  assign keys_if.keycode = keycode;

  key_decode #(.KEYS(KEYS)) u_key_decode (.kb(keys_if.slave));

  assign lvl_idx = 32'(level);
  assign spawn   = spawn_pos(lvl_idx);

`ifdef PLAYER_CHECKPOINT_EN
  pos_t ckpt_q, ckpt_d;
  assign respawn = ckpt_q;
`else
  logic unused_checkpoint;
  assign unused_checkpoint = checkpoint_hit;
  assign respawn = spawn;
`endif

  // W beats S and D beats A even when the winner is blocked by a wall.
  always_comb begin
    dx = 0;
    dy = 0;
    if (keys_if.right)     dx = border_right  ? 0 : STEP;
    else if (keys_if.left) dx = border_left   ? 0 : -STEP;
    if (keys_if.up)        dy = border_top    ? 0 : -STEP;
    else if (keys_if.down) dy = border_bottom ? 0 : STEP;
    moved.x = clamp_axis(int'(pos_q.x) + dx, SIZE, SCREEN_X_MAX - SIZE);
    moved.y = clamp_axis(int'(pos_q.y) + dy, SIZE, SCREEN_Y_MAX - SIZE);
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= WAIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (level_wait) begin
      state_d = WAIT;
    end else begin
      case (state_q)
        WAIT:    if (level_active) state_d = PLAY;
        PLAY:    if (!level_active) state_d = WAIT;
                 else if (kill)     state_d = DEAD;
        DEAD:    if (cnt_q == LAST_FRAME) state_d = PLAY;
        default: state_d = WAIT;
      endcase
    end
  end

  always_comb begin
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    deaths_d = deaths_q;
    coin_d   = '0;
`ifdef PLAYER_CHECKPOINT_EN
    ckpt_d   = ckpt_q;
`endif
    dead     = (state_q == DEAD);
    case (state_q)
      WAIT: begin
        pos_d = spawn;
        cnt_d = '0;
`ifdef PLAYER_CHECKPOINT_EN
        ckpt_d = spawn;
`endif
      end
      PLAY: begin
        if (state_d == DEAD) begin
          cnt_d  = '0;
          coin_d = NUM_LEVELS'(1) << level;
          if (deaths_q != '1) deaths_d = deaths_q + 16'd1;
        end else if (state_d == PLAY) begin
          pos_d = moved;
`ifdef PLAYER_CHECKPOINT_EN
          if (checkpoint_hit) ckpt_d = pos_q;
`endif
        end
      end
      DEAD: begin
        if (state_d == PLAY) begin
          pos_d = respawn;
          cnt_d = '0;
        end else if (state_d == DEAD) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_q    <= SPAWN0;
      cnt_q    <= '0;
      deaths_q <= '0;
      coin_q   <= '0;
`ifdef PLAYER_CHECKPOINT_EN
      ckpt_q   <= SPAWN0;
`endif
    end else begin
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      deaths_q <= deaths_d;
      coin_q   <= coin_d;
`ifdef PLAYER_CHECKPOINT_EN
      ckpt_q   <= ckpt_d;
`endif
    end
  end

  assign PlayerX     = pos_q.x;
  assign PlayerY     = pos_q.y;
  assign PlayerS     = 10'(SIZE);
  assign coin_reset  = coin_q;
  assign death_count = deaths_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: a motion vector table plus hand-written
// death, respawn, checkpoint, abort and level-exit sequences.
module tb_player_motion;

  logic        frame_clk = 1'b0;
  logic        Reset_n;
  logic [1:0]  level;
  logic        level_wait, level_active, kill, checkpoint_hit;
  logic        btop, bbot, bleft, bright;
  logic [9:0]  PlayerX, PlayerY, PlayerS;
  logic [2:0]  coin_reset;
  logic        dead;
  logic [15:0] death_count;

  int n_tests = 0;
  int n_fail  = 0;

  player_motion_if #(.KEYS(6)) kb_if ();
  key_decode #(.KEYS(6)) u_tb_dec (.kb(kb_if.slave));

  player_motion #(
    .NUM_LEVELS(3), .KEYS(6), .STEP(1), .SIZE(6), .DEATH_FRAMES(30)
  ) dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(kb_if.keycode),
    .level(level), .level_wait(level_wait), .level_active(level_active),
    .kill(kill), .checkpoint_hit(checkpoint_hit),
    .border_top(btop), .border_bottom(bbot), .border_left(bleft), .border_right(bright),
    .PlayerX(PlayerX), .PlayerY(PlayerY), .PlayerS(PlayerS),
    .coin_reset(coin_reset), .dead(dead), .death_count(death_count)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      @(negedge frame_clk);
    end
  endtask

  // Counts dead-high frames until dead drops, with a hard frame budget.
  task automatic finish_death(input string name, input int already);
    int f;
    f = already;
    while (f < 100) begin
      tick(1);
      if (dead !== 1'b1) break;
      f++;
    end
    chk(name, f, 30);
  endtask

  typedef struct {
    logic [47:0] kc;
    logic [3:0]  brd;     // top, bottom, left, right
    int          frames;
    int          ex;
    int          ey;
    logic [3:0]  dir;     // up, down, left, right
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  initial begin
    vt[0]  = '{48'h0000_0000_0007, 4'b0000,  10, 180, 240, 4'b0001};
    vt[1]  = '{48'h0000_1A16_0000, 4'b0000,   5, 180, 235, 4'b1100};
    vt[2]  = '{48'h0000_1A16_0000, 4'b1000,   3, 180, 235, 4'b1100};
    vt[3]  = '{48'h0700_0000_0004, 4'b0000,   4, 184, 235, 4'b0011};
    vt[4]  = '{48'h0700_0000_0004, 4'b0001,   2, 184, 235, 4'b0011};
    vt[5]  = '{48'h0000_2C00_0016, 4'b0000,   5, 184, 240, 4'b0100};
    vt[6]  = '{48'h0000_2C00_0016, 4'b0100,   2, 184, 240, 4'b0100};
    vt[7]  = '{48'h0000_0400_0000, 4'b0000,   4, 180, 240, 4'b0010};
    vt[8]  = '{48'h0000_0400_0000, 4'b0010,   3, 180, 240, 4'b0010};
    vt[9]  = '{48'h2C2C_2C2C_2C2C, 4'b0000,   3, 180, 240, 4'b0000};
    vt[10] = '{48'h0000_0400_0000, 4'b0000, 173,   7, 240, 4'b0010};
    vt[11] = '{48'h0000_0400_0000, 4'b0000,   1,   6, 240, 4'b0010};
    vt[12] = '{48'h0000_0400_0000, 4'b0000,   5,   6, 240, 4'b0010};
    vt[13] = '{48'h0000_0000_001A, 4'b0000, 234,   6,   6, 4'b1000};
    vt[14] = '{48'h0000_0000_041A, 4'b0000,   3,   6,   6, 4'b1010};
    vt[15] = '{48'h0000_0000_1607, 4'b0000, 194, 200, 200, 4'b0101};
    vt[16] = '{48'h0000_0000_0016, 4'b0000,  40, 200, 240, 4'b0100};

    Reset_n = 1'b1; level = 2'd0; level_wait = 1'b0; level_active = 1'b0;
    kill = 1'b0; checkpoint_hit = 1'b0;
    {btop, bbot, bleft, bright} = 4'b0000;
    kb_if.keycode = '0;
    #2 Reset_n = 1'b0;
    tick(2);
    chk("rst_x", PlayerX, 170);
    chk("rst_y", PlayerY, 240);
    chk("rst_dead", dead, 0);
    chk("rst_deaths", death_count, 0);
    chk("rst_coin", coin_reset, 0);
    chk("player_s", PlayerS, 6);
    level_active = 1'b1;
    Reset_n = 1'b1;
    tick(1);
    chk("wait_to_play_x", PlayerX, 170);

    for (int i = 0; i < NV; i++) begin
      kb_if.keycode = vt[i].kc;
      {btop, bbot, bleft, bright} = vt[i].brd;
      tick(vt[i].frames);
      chk($sformatf("vec%0d_x", i), PlayerX, vt[i].ex);
      chk($sformatf("vec%0d_y", i), PlayerY, vt[i].ey);
      chk($sformatf("vec%0d_dir", i),
          {kb_if.up, kb_if.down, kb_if.left, kb_if.right}, vt[i].dir);
    end
    kb_if.keycode = '0;
    {btop, bbot, bleft, bright} = 4'b0000;

    // Kill at (200,240); a second kill mid-death must be ignored.
    kill = 1'b1;
    tick(1);
    chk("kill_dead", dead, 1);
    chk("kill_coin", coin_reset, 3'b001);
    chk("kill_deaths", death_count, 1);
    chk("kill_hold_x", PlayerX, 200);
    kill = 1'b0;
    kb_if.keycode = 48'h0000_0000_0007;
    tick(1);
    chk("coin_one_cycle", coin_reset, 0);
    chk("dead_frozen_x", PlayerX, 200);
    kill = 1'b1;
    tick(1);
    kill = 1'b0;
    finish_death("dead_frames", 3);
    chk("respawn_x", PlayerX, 170);
    chk("respawn_y", PlayerY, 240);
    chk("kill_in_dead_ignored", death_count, 1);
    kb_if.keycode = '0;

    // Checkpoint touched at (190,240), then a kill further on.
    kb_if.keycode = 48'h0000_0000_0007;
    tick(20);
    chk("ckpt_pre_x", PlayerX, 190);
    kb_if.keycode = '0;
    checkpoint_hit = 1'b1;
    tick(1);
    checkpoint_hit = 1'b0;
    kb_if.keycode = 48'h0000_0000_0007;
    tick(10);
    chk("ckpt_kill_x", PlayerX, 200);
    kb_if.keycode = '0;
    kill = 1'b1;
    tick(1);
    kill = 1'b0;
    finish_death("ckpt_dead_frames", 1);
`ifdef PLAYER_CHECKPOINT_EN
    chk("ckpt_respawn_x", PlayerX, 190);
`else
    chk("ckpt_respawn_x", PlayerX, 170);
`endif
    chk("ckpt_deaths", death_count, 2);

    // Asynchronous reset, then kill and checkpoint on the same frame.
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_x", PlayerX, 170);
    chk("async_rst_deaths", death_count, 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    tick(1);
    kb_if.keycode = 48'h0000_0000_0007;
    tick(40);
    chk("kc_pre_x", PlayerX, 210);
    kb_if.keycode = '0;
    kill = 1'b1;
    checkpoint_hit = 1'b1;
    tick(1);
    kill = 1'b0;
    checkpoint_hit = 1'b0;
    chk("kc_dead", dead, 1);
    finish_death("kc_dead_frames", 1);
    chk("kc_respawn_x", PlayerX, 170);
    chk("kc_respawn_y", PlayerY, 240);
    chk("kc_deaths", death_count, 1);

    // level_wait on the tenth DEAD frame aborts the death and reloads level 1.
    kill = 1'b1;
    tick(1);
    kill = 1'b0;
    chk("abort_coin", coin_reset, 3'b001);
    tick(9);
    chk("abort_frame10_dead", dead, 1);
    level_wait = 1'b1;
    level = 2'd1;
    level_active = 1'b0;
    tick(1);
    chk("abort_dead", dead, 0);
    chk("abort_coin0", coin_reset, 0);
    tick(1);
    chk("abort_x", PlayerX, 160);
    chk("abort_y", PlayerY, 240);
    chk("abort_coin1", coin_reset, 0);
    level_wait = 1'b0;
    kill = 1'b1;
    tick(1);
    kill = 1'b0;
    chk("wait_kill_dead", dead, 0);
    chk("wait_kill_deaths", death_count, 2);
    chk("wait_hold_x", PlayerX, 160);

    // Dropping level_active in PLAY returns to WAIT and reloads the spawn.
    level_active = 1'b1;
    tick(1);
    kb_if.keycode = 48'h0000_0000_0007;
    tick(5);
    chk("l1_move_x", PlayerX, 165);
    level_active = 1'b0;
    tick(1);
    chk("exit_hold_x", PlayerX, 165);
    tick(1);
    chk("exit_spawn_x", PlayerX, 160);
    kb_if.keycode = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/player_motion.md
PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 SHALL have parameter NUM_LEVELS, default 3, number of levels and spawn-table entries.
REQ-002 SHALL have parameter KEYS, default 6, number of simultaneous keycode slots scanned.
REQ-003 SHALL have parameter STEP, default 1, pixels moved per frame per axis.
REQ-004 SHALL have parameter SIZE, default 6, player half-size in pixels, driven on PlayerS.
REQ-005 SHALL have parameter DEATH_FRAMES, default 30, frames frozen after a kill.
REQ-006 SHALL have ports, in this order:
- frame_clk  input  1  sole clock, one edge per video frame.
- Reset_n  input  1  asynchronous, active-low reset.
- keycode  input  KEYS x 8  USB HID keycodes.
- level  input  $clog2(NUM_LEVELS)  current level index.
- level_wait  input  1  pre-level wait state.
- level_active  input  1  level in play.
- kill  input  1  enemy collision this frame.
- checkpoint_hit  input  1  player on checkpoint tile.
- border_top, border_bottom, border_left, border_right  input  1 each  wall blocks that direction.
- PlayerX, PlayerY  output  10  player centre.
- PlayerS  output  10  constant SIZE.
- coin_reset  output  NUM_LEVELS  one-cycle pulse per level.
- dead  output  1  high in DEAD.
- death_count  output  16  saturating death counter.

Function
REQ-007 SHALL implement FSM states WAIT, PLAY, DEAD.
REQ-008 In WAIT, each edge SHALL load PlayerX/Y and checkpoint with SPAWN[level]; level_active=1 and level_wait=0 SHALL move to PLAY next edge.
REQ-009 In PLAY, each edge SHALL sample keys and update position on that same edge (zero-frame lag).
- W=0x1A up, S=0x16 down, A=0x04 left, D=0x07 right; W beats S, D beats A.
- Any slot matching counts.
- A direction whose border input is high SHALL give zero motion on that axis.
REQ-010 Position SHALL clamp to [SIZE, 639-SIZE] on X and [SIZE, 479-SIZE] on Y; no 10-bit wrap.
REQ-011 kill in PLAY SHALL enter DEAD, hold position, set death_count+1 (saturating at 0xFFFF), and pulse coin_reset[level] for exactly one cycle.
REQ-012 DEAD SHALL last exactly DEATH_FRAMES edges, then load position from checkpoint and return to PLAY.
REQ-013 kill and checkpoint_hit on the same edge: kill SHALL win; checkpoint unchanged.
REQ-014 level_wait=1 in any state SHALL force WAIT next edge; a DEAD countdown in progress SHALL abort with no respawn.
REQ-015 level_active=0 in PLAY SHALL return to WAIT.
REQ-016 kill during DEAD or WAIT SHALL be ignored.

Reset
REQ-017 Reset_n low SHALL asynchronously set state WAIT, PlayerX/Y and checkpoint to SPAWN[0], coin_reset 0, death_count 0, dead 0, and the DEAD counter 0.

Configuration
REQ-018 Macro PLAYER_CHECKPOINT_EN defined: checkpoint_hit in PLAY SHALL latch the current PlayerX/Y into checkpoint.
REQ-019 Macro PLAYER_CHECKPOINT_EN undefined: checkpoint_hit SHALL be ignored and respawn SHALL always use SPAWN[level].

Structure
REQ-020 Package player_pkg SHALL hold:
- state enum
- keycode constants
- screen bounds 639/479
- SPAWN table: {(170,240), (160,240), (320,240)}
REQ-021 Sub-module key_decode SHALL reduce keycode[KEYS] to four direction bits.

Verification
REQ-022 Reset, level=0, level_active=1 -> PlayerX/Y=170/240; hold D 10 frames -> PlayerX=180.
REQ-023 Hold W+S with border_top=0 -> PlayerY decrements 1/frame; border_top=1 -> PlayerY frozen.
REQ-024 PlayerX=7, hold A -> PlayerX=6 and stays 6 (clamp).
REQ-025 kill at (200,240) -> coin_reset[0] high one cycle, dead=1 for 30 frames, then respawn at (170,240), or at the checkpoint when PLAYER_CHECKPOINT_EN is defined.
REQ-026 kill and checkpoint_hit together at (210,240), then DEAD expires -> respawn at (170,240); death_count=1.
REQ-027 level_wait=1 at frame 10 of DEAD, level=1 -> WAIT, position (160,240), no coin_reset pulse.
